// File: rtl/loader_pkg.sv
// Shared types and defaults for the byte-serial program loader.
// Build option: LOADER_CHECKSUM_EN adds the trailing checksum byte and the err path.
package loader_pkg;

    localparam int unsigned SYNC_STAGES_DEFAULT = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_VALID,
        S_WRITE,
        S_WAIT_RELEASE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } loader_state_t;

endpackage

// File: rtl/loader_sync.sv
// Multi-flop synchronizer for a single asynchronous control input.
module loader_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/program_loader.sv
// Loads a RAM image byte-by-byte from the host under a 4-phase valid/ack handshake.
// Build option: LOADER_CHECKSUM_EN expects one trailing checksum byte and enables err.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned RAM_BYTES   = 16,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT,
    localparam int unsigned ADDR_W     = $clog2(RAM_BYTES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              start,
    output logic              in_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_data,
    output logic              ram_we,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int unsigned CNT_W = ADDR_W + 1;
`ifdef LOADER_CHECKSUM_EN
    localparam int unsigned IMAGE_LEN = RAM_BYTES + 1;
`else
    localparam int unsigned IMAGE_LEN = RAM_BYTES;
`endif

    logic valid_s;
    logic start_s;
    logic start_rise_c;

    loader_state_t     state_q;
    logic [CNT_W-1:0]  count_q;
    logic              start_prev_q;
    logic              in_ack_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [7:0]        ram_data_q;
    logic              ram_we_q;
    logic              cpu_hold_q;
    logic              done_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        sum_q;
    logic              err_q;
`endif

    loader_sync #(.STAGES(SYNC_STAGES)) u_sync_valid (
        .clk (clk),
        .rst (rst),
        .d_i (in_valid),
        .q_o (valid_s)
    );

    loader_sync #(.STAGES(SYNC_STAGES)) u_sync_start (
        .clk (clk),
        .rst (rst),
        .d_i (start),
        .q_o (start_s)
    );

    assign start_rise_c = start_s & ~start_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            start_prev_q <= 1'b0;
            in_ack_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_data_q   <= '0;
            ram_we_q     <= 1'b0;
            cpu_hold_q   <= 1'b0;
            done_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            start_prev_q <= start_s;
            ram_we_q     <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start_rise_c) begin
                        done_q     <= 1'b0;
                        count_q    <= '0;
                        cpu_hold_q <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        err_q      <= 1'b0;
                        sum_q      <= '0;
`endif
                        state_q    <= S_WAIT_VALID;
                    end
                end
                S_WAIT_VALID: begin
                    if (valid_s) begin
                        in_ack_q <= 1'b1;
                        if (count_q < CNT_W'(RAM_BYTES)) begin
                            // Write strobe, address and data are presented during S_WRITE.
                            ram_data_q <= in_data;
                            ram_addr_q <= count_q[ADDR_W-1:0];
                            ram_we_q   <= 1'b1;
                            state_q    <= S_WRITE;
                        end else begin
`ifdef LOADER_CHECKSUM_EN
                            sum_q   <= sum_q + in_data;
                            count_q <= count_q + CNT_W'(1);
`endif
                            state_q <= S_WAIT_RELEASE;
                        end
                    end
                end
                S_WRITE: begin
`ifdef LOADER_CHECKSUM_EN
                    sum_q   <= sum_q + ram_data_q;
`endif
                    count_q <= count_q + CNT_W'(1);
                    state_q <= S_WAIT_RELEASE;
                end
                S_WAIT_RELEASE: begin
                    if (!valid_s) begin
                        in_ack_q <= 1'b0;
                        state_q  <= (count_q == CNT_W'(IMAGE_LEN)) ? S_CHECK : S_WAIT_VALID;
                    end
                end
                S_CHECK: begin
`ifdef LOADER_CHECKSUM_EN
                    if (sum_q == 8'h00) begin
                        done_q     <= 1'b1;
                        cpu_hold_q <= 1'b0;
                        state_q    <= S_DONE;
                    end else begin
                        err_q      <= 1'b1;
                        state_q    <= S_ERROR;
                    end
`else
                    done_q     <= 1'b1;
                    cpu_hold_q <= 1'b0;
                    state_q    <= S_DONE;
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ack   = in_ack_q;
    assign ram_addr = ram_addr_q;
    assign ram_data = ram_data_q;
    assign ram_we   = ram_we_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
`ifdef LOADER_CHECKSUM_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule
